// File: rtl/sw_alloc_wormhole_pkg.sv
// Shared NoC router constants and types used by the wormhole switch allocator.
package sw_alloc_wormhole_pkg;

  localparam int PORT_NUM_DEF = 5;
  localparam int VC_NUM_DEF   = 4;
  localparam int PORT_W       = $clog2(PORT_NUM_DEF);
  localparam int VC_W         = $clog2(VC_NUM_DEF);

  typedef logic [PORT_W-1:0] port_idx_t;

  // Per-output wormhole ownership: which (input, VC) holds the output mid-packet.
  typedef struct packed {
    logic            lock_vld;
    port_idx_t       lock_in;
    logic [VC_W-1:0] lock_vc;
  } out_lock_t;

endpackage

// File: rtl/rr_arb_upd.sv
// Round-robin arbiter whose priority pointer moves to one past the winner
// only when the caller confirms the grant was actually issued (upd_en).
module rr_arb_upd #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd_en,
  output logic [N-1:0] gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    int idx;
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx] && (gnt == '0)) begin
        gnt[idx] = 1'b1;
        ptr_d    = (idx == N - 1) ? '0 : IW'(idx + 1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  ptr_q <= '0;
    else if (upd_en && |gnt)  ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sw_alloc_wormhole.sv
// Two-stage separable switch allocator (VC per input, then input per output)
// with registered grants and credit gating. Wormhole locking is built only when
// SW_ALLOC_LOCK_EN is defined; otherwise every flit is arbitrated independently.
module sw_alloc_wormhole
  import sw_alloc_wormhole_pkg::*;
#(
  parameter int PORT_NUM = PORT_NUM_DEF,
  parameter int VC_NUM   = VC_NUM_DEF,
  parameter int PW       = $clog2(PORT_NUM)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]         req_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0][PW-1:0] out_port_i,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]         tail_i,
  input  logic [PORT_NUM-1:0]                    out_ready_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]         grant_o,
  output logic [PORT_NUM-1:0][PW-1:0]            xbar_sel_o,
  output logic [PORT_NUM-1:0]                    xbar_vld_o
);

  logic [PORT_NUM-1:0][PORT_NUM-1:0][VC_NUM-1:0] may_use;   // [out][in][vc]
  logic [PORT_NUM-1:0]                           out_locked;

  logic [PORT_NUM-1:0][VC_NUM-1:0]   s1_req, s1_gnt;
  logic [PORT_NUM-1:0][PW-1:0]       s1_tgt;
  logic [PORT_NUM-1:0]               s1_vld, s1_upd;
  logic [PORT_NUM-1:0][PORT_NUM-1:0] s2_req, s2_gnt;        // [out][in]
  logic [PORT_NUM-1:0]               s2_upd;

  logic [PORT_NUM-1:0][VC_NUM-1:0]   grant_d;
  logic [PORT_NUM-1:0][PW-1:0]       sel_d;
  logic [PORT_NUM-1:0]               vld_d;

`ifdef SW_ALLOC_LOCK_EN
  out_lock_t [PORT_NUM-1:0] lock_q, lock_d;

  always_comb begin
    out_locked = '0;
    may_use    = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      out_locked[o] = lock_q[o].lock_vld;
      for (int i = 0; i < PORT_NUM; i++)
        for (int v = 0; v < VC_NUM; v++)
          may_use[o][i][v] = !lock_q[o].lock_vld ||
                             ((lock_q[o].lock_in == port_idx_t'(i)) &&
                              (lock_q[o].lock_vc == VC_W'(v)));
    end
  end

  // A granted non-tail flit claims the output; the owner's tail releases it.
  always_comb begin
    lock_d = lock_q;
    for (int o = 0; o < PORT_NUM; o++)
      for (int i = 0; i < PORT_NUM; i++)
        for (int v = 0; v < VC_NUM; v++)
          if (s2_gnt[o][i] && s1_gnt[i][v]) begin
            lock_d[o].lock_vld = !tail_i[i][v];
            lock_d[o].lock_in  = port_idx_t'(i);
            lock_d[o].lock_vc  = VC_W'(v);
          end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_q <= '0;
    else     lock_q <= lock_d;
  end
`else
  logic unused_tail;
  assign unused_tail = ^tail_i;
  assign out_locked  = '0;
  assign may_use     = '1;
`endif

  // Eligibility: valid target, downstream credit, and output free or owned by us.
  always_comb begin
    s1_req = '0;
    for (int i = 0; i < PORT_NUM; i++)
      for (int v = 0; v < VC_NUM; v++)
        for (int o = 0; o < PORT_NUM; o++)
          if (req_i[i][v] && (out_port_i[i][v] == PW'(o)) &&
              out_ready_i[o] && may_use[o][i][v])
            s1_req[i][v] = 1'b1;
  end

  for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_s1
    rr_arb_upd #(.N(VC_NUM)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (s1_req[gi]),
      .upd_en (s1_upd[gi]),
      .gnt    (s1_gnt[gi])
    );
  end

  always_comb begin
    s1_tgt = '0;
    s1_vld = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      s1_vld[i] = |s1_gnt[i];
      for (int v = 0; v < VC_NUM; v++)
        if (s1_gnt[i][v]) s1_tgt[i] = out_port_i[i][v];
    end
  end

  always_comb begin
    s2_req = '0;
    for (int o = 0; o < PORT_NUM; o++)
      for (int i = 0; i < PORT_NUM; i++)
        s2_req[o][i] = s1_vld[i] && (s1_tgt[i] == PW'(o));
  end

  // A locked output sees only its owner as a request, so arbitration there is a
  // pass-through; its pointer is simply held.
  assign s2_upd = ~out_locked;

  for (genvar go = 0; go < PORT_NUM; go++) begin : g_s2
    rr_arb_upd #(.N(PORT_NUM)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (s2_req[go]),
      .upd_en (s2_upd[go]),
      .gnt    (s2_gnt[go])
    );
  end

  always_comb begin
    s1_upd  = '0;
    grant_d = '0;
    sel_d   = '0;
    vld_d   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      vld_d[o] = |s2_gnt[o];
      for (int i = 0; i < PORT_NUM; i++)
        if (s2_gnt[o][i]) begin
          sel_d[o]   = PW'(i);
          grant_d[i] = s1_gnt[i];
          s1_upd[i]  = !out_locked[o];
        end
    end
  end

  // NOTE: grants, selects and locks are control state and must be cleared by
  // reset so a half-sent packet cannot keep an output claimed afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_o    <= '0;
      xbar_sel_o <= '0;
      xbar_vld_o <= '0;
    end else begin
      grant_o    <= grant_d;
      xbar_sel_o <= sel_d;
      xbar_vld_o <= vld_d;
    end
  end

endmodule
